split_complex_stream: RTL and testbench

- Splits one AXI-stream of packed complex samples {I,Q} into two independent real AXI-streams, one for I and one for Q.
- It is the inverse of the complex join path. It sits in the compute-engine clock domain between a chdr_deframer and two per-channel processing chains or framers.
- Each output has its own FIFO, so the two consumers may stall independently up to the FIFO depth.
- Each output can be enabled or disabled per packet, so a single-channel consumer does not need a dummy sink.

---
 rtl/split_complex_stream.sv | 204 ++++++++++++++++++++
 tb/tb_split_complex_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/split_complex_stream.sv
// Splits a packed {I,Q} AXI-stream into independent I and Q real streams.
// Each output has its own small first-word-fall-through FIFO and a per-packet enable.

module split_complex_stream_fifo #(
  parameter int W  = 17,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  input  logic         ready_i
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [W-1:0]  hold_q;
  logic          push;
  logic          pop;

  // Full is judged on registered occupancy only, so a same-cycle read never frees a slot.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign valid_o = (count_q != (AW+1)'(0));
  assign push    = wr_i && !full_o;
  assign pop     = valid_o && ready_i;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : hold_q;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and the last-popped word shown while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
      hold_q   <= W'(0);
    end else if (clear) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end
endmodule

module split_complex_stream #(
  parameter int WIDTH     = 16,
  parameter int FIFO_SIZE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en_i,
  input  logic               en_q,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [WIDTH-1:0]   oi_tdata,
  output logic               oi_tlast,
  output logic               oi_tvalid,
  input  logic               oi_tready,
  output logic [WIDTH-1:0]   oq_tdata,
  output logic               oq_tlast,
  output logic               oq_tvalid,
  input  logic               oq_tready,
  output logic [31:0]        pkt_count
);
  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        lat_i_q;
  logic        lat_i_d;
  logic        lat_q_q;
  logic        lat_q_d;
  logic [31:0] pkt_count_q;
  logic [31:0] pkt_count_d;
  logic        act_i;
  logic        act_q;
  logic        full_i;
  logic        full_q;
  logic        xfer;
  logic [WIDTH:0] rd_i;
  logic [WIDTH:0] rd_q;

  // Enables are live between packets and frozen for the remainder of an open packet.
  assign act_i    = (state_q == IN_PKT) ? lat_i_q : en_i;
  assign act_q    = (state_q == IN_PKT) ? lat_q_q : en_q;
  assign i_tready = !reset && !clear && (!act_i || !full_i) && (!act_q || !full_q);
  assign xfer     = i_tvalid && i_tready;
  assign pkt_count = pkt_count_q;

  // Packet FSM, enable latch and packet counter next-state.
  always_comb begin
    state_d     = state_q;
    lat_i_d     = lat_i_q;
    lat_q_d     = lat_q_q;
    pkt_count_d = pkt_count_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (!i_tlast) begin
            state_d = IN_PKT;
            lat_i_d = en_i;
            lat_q_d = en_q;
          end else begin
            state_d = IDLE;
          end
        end
        IN_PKT: begin
          if (i_tlast) begin
            state_d = IDLE;
          end else begin
            state_d = IN_PKT;
          end
        end
        default: state_d = IDLE;
      endcase
      if (i_tlast) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end else begin
        pkt_count_d = pkt_count_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers; clear behaves like reset for the control path.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= IDLE;
      lat_i_q     <= 1'b0;
      lat_q_q     <= 1'b0;
      pkt_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      lat_i_q     <= lat_i_d;
      lat_q_q     <= lat_q_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  split_complex_stream_fifo #(.W(WIDTH + 1), .AW(FIFO_SIZE)) u_fifo_i (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_i    (xfer && act_i),
    .wdata_i ({i_tlast, i_tdata[2*WIDTH-1:WIDTH]}),
    .full_o  (full_i),
    .rdata_o (rd_i),
    .valid_o (oi_tvalid),
    .ready_i (oi_tready)
  );

  split_complex_stream_fifo #(.W(WIDTH + 1), .AW(FIFO_SIZE)) u_fifo_q (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_i    (xfer && act_q),
    .wdata_i ({i_tlast, i_tdata[WIDTH-1:0]}),
    .full_o  (full_q),
    .rdata_o (rd_q),
    .valid_o (oq_tvalid),
    .ready_i (oq_tready)
  );

  assign oi_tlast = rd_i[WIDTH];
  assign oi_tdata = rd_i[WIDTH-1:0];
  assign oq_tlast = rd_q[WIDTH];
  assign oq_tdata = rd_q[WIDTH-1:0];
endmodule

// File: tb/tb_split_complex_stream.sv
// Scoreboard bench for split_complex_stream: the driver pushes expected I/Q words,
// independent monitors pop and compare on every output handshake.

module tb_split_complex_stream;
  logic        clk = 1'b0;
  logic        reset, clear, en_i, en_q;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [15:0] oi_tdata, oq_tdata;
  logic        oi_tlast, oi_tvalid, oi_tready;
  logic        oq_tlast, oq_tvalid, oq_tready;
  logic [31:0] pkt_count;

  int checks = 0;
  int failures = 0;
  int i_pops = 0;
  int q_pops = 0;
  int acc_cnt = 0;
  int stalls = 0;
  logic [16:0] exp_i[$];
  logic [16:0] exp_q[$];
  logic        m_inpkt = 1'b0;
  logic        m_li = 1'b0;
  logic        m_lq = 1'b0;
  logic [31:0] exp_pkt = 32'd0;

  split_complex_stream #(.WIDTH(16), .FIFO_SIZE(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .en_i(en_i), .en_q(en_q),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .oi_tdata(oi_tdata), .oi_tlast(oi_tlast), .oi_tvalid(oi_tvalid), .oi_tready(oi_tready),
    .oq_tdata(oq_tdata), .oq_tlast(oq_tlast), .oq_tvalid(oq_tvalid), .oq_tready(oq_tready),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && oi_tvalid && oi_tready) begin
      if (exp_i.size() == 0) begin
        checks++; failures++;
        $display("FAIL oi_unexpected: got %h expected none", {oi_tlast, oi_tdata});
      end else begin
        chk("oi_beat", {15'd0, oi_tlast, oi_tdata}, {15'd0, exp_i.pop_front()});
      end
      i_pops++;
    end
    if (!reset && oq_tvalid && oq_tready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL oq_unexpected: got %h expected none", {oq_tlast, oq_tdata});
      end else begin
        chk("oq_beat", {15'd0, oq_tlast, oq_tdata}, {15'd0, exp_q.pop_front()});
      end
      q_pops++;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic ei, input logic eq);
    int wait_n;
    logic ai, aq;
    wait_n = 0;
    i_tdata = d; i_tlast = last; i_tvalid = 1'b1; en_i = ei; en_q = eq;
    @(negedge clk);
    while (!i_tready && wait_n < 200) begin
      wait_n++; stalls++;
      @(negedge clk);
    end
    if (!i_tready) begin
      checks++; failures++;
      $display("FAIL send_timeout: got i_tready=0 expected 1 for data %h", d);
    end else begin
      ai = m_inpkt ? m_li : ei;
      aq = m_inpkt ? m_lq : eq;
      if (ai) exp_i.push_back({last, d[31:16]});
      if (aq) exp_q.push_back({last, d[15:0]});
      if (last) begin
        exp_pkt = exp_pkt + 32'd1;
        m_inpkt = 1'b0;
      end else if (!m_inpkt) begin
        m_inpkt = 1'b1; m_li = ei; m_lq = eq;
      end
      acc_cnt++;
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [15:0] bi, input logic [15:0] bq,
                          input logic ei0, input logic eq0, input logic ein, input logic eqn);
    for (int k = 0; k < n; k++) begin
      send_beat({16'(bi + k), 16'(bq + k)}, (k == n - 1), (k == 0) ? ei0 : ein, (k == 0) ? eq0 : eqn);
    end
  endtask

  task automatic drain(input string name);
    repeat (12) @(posedge clk);
    #1;
    chk({name, "_i_empty"}, exp_i.size(), 32'd0);
    chk({name, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int pi, pq;
    logic [31:0] pk;
    reset = 1'b1; clear = 1'b0; en_i = 1'b0; en_q = 1'b0;
    i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0;
    oi_tready = 1'b0; oq_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_tready", {31'd0, i_tready}, 32'd0);
    chk("rst_valids", {30'd0, oi_tvalid, oq_tvalid}, 32'd0);
    chk("rst_lasts", {30'd0, oi_tlast, oq_tlast}, 32'd0);
    chk("rst_data", {oi_tdata, oq_tdata}, 32'd0);
    chk("rst_pkt", pkt_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full-rate 8-beat packet: one-cycle latency and no bubbles.
    oi_tready = 1'b1; oq_tready = 1'b1; stalls = 0;
    send_pkt(8, 16'h1000, 16'h2000, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t1_stalls", stalls, 32'd0);
    chk("t1_i_pops_at_last", i_pops, 32'd7);
    chk("t1_q_pops_at_last", q_pops, 32'd7);
    drain("t1");
    chk("t1_pkt", pkt_count, 32'd1);

    // Q stalled: input backs up once FIFO_Q holds four words.
    oq_tready = 1'b0; acc_cnt = 0; pq = q_pops;
    fork
      send_pkt(8, 16'h3000, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t2_accepted", acc_cnt, 32'd4);
        chk("t2_i_tready", {31'd0, i_tready}, 32'd0);
        chk("t2_oq_tvalid", {31'd0, oq_tvalid}, 32'd1);
        chk("t2_q_pops", q_pops - pq, 32'd0);
        oq_tready = 1'b1;
      end
    join
    drain("t2");
    chk("t2_q_total", q_pops - pq, 32'd8);

    // Per-packet enables, with mid-packet toggles that must not change routing.
    pi = i_pops; pq = q_pops;
    send_pkt(3, 16'h5000, 16'h6000, 1'b1, 1'b0, 1'b1, 1'b1);
    send_pkt(3, 16'h5100, 16'h6100, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("t3");
    chk("t3_i_count", i_pops - pi, 32'd6);
    chk("t3_q_count", q_pops - pq, 32'd3);

    // Both disabled: data discarded, never back-pressured, packets still counted.
    oi_tready = 1'b0; oq_tready = 1'b0; stalls = 0; pk = pkt_count;
    for (int k = 0; k < 5; k++) begin
      send_beat({16'(16'h9000 + k), 16'(16'hA000 + k)}, 1'b1, 1'b0, 1'b0);
    end
    chk("t4_stalls", stalls, 32'd0);
    chk("t4_valids", {30'd0, oi_tvalid, oq_tvalid}, 32'd0);
    chk("t4_pkt_delta", pkt_count - pk, 32'd5);
    chk("t4_pkt", pkt_count, exp_pkt);

    // Clear in the middle of a stalled packet.
    send_beat({16'hB000, 16'hC000}, 1'b0, 1'b1, 1'b1);
    send_beat({16'hB001, 16'hC001}, 1'b0, 1'b1, 1'b1);
    clear = 1'b1; i_tdata = {16'hB002, 16'hC002}; i_tlast = 1'b0; i_tvalid = 1'b1;
    @(negedge clk);
    chk("t5_tready_in_clear", {31'd0, i_tready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; i_tvalid = 1'b0;
    exp_i.delete(); exp_q.delete(); m_inpkt = 1'b0; exp_pkt = 32'd0;
    chk("t5_valids_after_clear", {30'd0, oi_tvalid, oq_tvalid}, 32'd0);
    chk("t5_pkt_after_clear", pkt_count, 32'd0);
    oi_tready = 1'b1; oq_tready = 1'b1;
    send_pkt(4, 16'h7000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("t5");
    chk("t5_pkt_after", pkt_count, 32'd1);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.pkt_count_q;
    exp_pkt = 32'hFFFF_FFFF;
    send_beat({16'hD000, 16'hE000}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_wrap", pkt_count, 32'd0);
    chk("t6_wrap_model", pkt_count, exp_pkt);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
